lm32_addsub_seq: RTL



---
 rtl/lm32_addsub_pkg.sv | 17 +
 rtl/lm32_addsub_slice.sv | 27 ++
 rtl/lm32_addsub_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lm32_addsub_pkg.sv
// Shared types and constants for the sliced LM32 adder/subtractor.
package lm32_addsub_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } addsub_state_e;

  localparam logic ADD = 1'b1;
  localparam logic SUB = 1'b0;

  // Slice counter width; a single-slice build still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned nseg);
    return (nseg > 1) ? $clog2(nseg) : 1;
  endfunction

endpackage

// File: rtl/lm32_addsub_slice.sv
// Combinational SEG_W-bit slice adder; B is optionally inverted for subtraction.
// msb_cin is only generated when LM32_ADDSUB_OVF_EN is defined.
module lm32_addsub_slice #(
  parameter int unsigned SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  input  logic             invert_b,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [SEG_W-1:0] b_eff;

  assign b_eff = b ^ {SEG_W{invert_b}};
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{SEG_W{1'b0}}, cin};

`ifdef LM32_ADDSUB_OVF_EN
  // Carry into the top bit recovered from the top-bit sum equation.
  assign msb_cin = a[SEG_W-1] ^ b_eff[SEG_W-1] ^ sum[SEG_W-1];
`else
  assign msb_cin = 1'b0;
`endif

endmodule

// File: rtl/lm32_addsub_seq.sv
// Multi-cycle add/subtract: one SEG_W slice per clock through a registered carry.
// Define LM32_ADDSUB_OVF_EN to enable the signed-overflow flag on ovf_o.
module lm32_addsub_seq
  import lm32_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_a_i,
  input  logic [WIDTH-1:0] data_b_i,
  input  logic             cin_i,
  input  logic             add_sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned NSEG = WIDTH / SEG_W;
  localparam int unsigned CW = cnt_width(NSEG);
  localparam logic [CW-1:0] LastSeg = CW'(NSEG - 1);

  addsub_state_e state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             sub_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic             cout_q, done_q;

  logic             accept, step, finish;
  logic [SEG_W-1:0] seg_sum;
  logic             seg_cout, seg_msb_cin;
  logic [WIDTH+SEG_W-1:0] acc_wide;
  logic [WIDTH-1:0] acc_next;

  lm32_addsub_slice #(
    .SEG_W(SEG_W)
  ) u_slice (
    .a       (a_q[SEG_W-1:0]),
    .b       (b_q[SEG_W-1:0]),
    .cin     (carry_q),
    .invert_b(sub_q),
    .sum     (seg_sum),
    .cout    (seg_cout),
    .msb_cin (seg_msb_cin)
  );

  // New slice enters at the top; after NSEG steps the register holds the full result.
  assign acc_wide = {seg_sum, acc_q} >> SEG_W;
  assign acc_next = WIDTH'(acc_wide);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          step = 1'b1;
          if (cnt_q == LastSeg) begin
            finish  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        a_q     <= data_a_i;
        b_q     <= data_b_i;
        sub_q   <= (add_sub_i == SUB);
        carry_q <= cin_i;
        cnt_q   <= '0;
      end else if (step) begin
        a_q     <= a_q >> SEG_W;
        b_q     <= b_q >> SEG_W;
        carry_q <= seg_cout;
        acc_q   <= acc_next;
        cnt_q   <= finish ? '0 : cnt_q + 1'b1;
      end else if (state_q == StRun) begin
        cnt_q <= '0;
      end
      if (finish) begin
        result_q <= acc_next;
        cout_q   <= seg_cout;
      end
    end
  end

`ifdef LM32_ADDSUB_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_q <= 1'b0;
    end else if (finish) begin
      ovf_q <= seg_msb_cin ^ seg_cout;
    end
  end

  assign ovf_o = ovf_q;
`else
  logic unused_msb_cin;

  assign unused_msb_cin = seg_msb_cin;
  assign ovf_o = 1'b0;
`endif

  assign busy_o   = (state_q == StRun);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign cout_o   = cout_q;

endmodule
